// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with IF/ID pipeline register.
// Issues fetch requests, absorbs cache misses as bubbles, honours hazard
// stalls, handles branch/jump redirects (draining an in-flight miss first),
// and stops permanently on halt until reset.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   ihit, imemload      instruction cache hit and returned word
//   stall               hold the IF/ID register
//   redirect_en/_pc     redirect pulse and target from a later stage
//   halt                halt observed at writeback
//   imemREN, imemaddr   instruction read request and address
//   instr, pc, incPC    IF/ID instruction, its address, address + 4
//   valid               IF/ID slot holds a real instruction
//   halted              fetch permanently stopped
//
// Optional feature: define FETCH_JUMP_PREDECODE_EN to redirect J/JAL
// directly in fetch instead of waiting for a later-stage redirect.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] incPC,
  output logic        valid,
  output logic        halted
);

  localparam int unsigned AW = 32;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] fpc_d;
  logic [AW-1:0] pend_q, pend_d;
  logic [AW-1:0] instr_d, pc_d, incpc_d;
  logic          valid_d, halted_d, ren_d;
  logic [AW-1:0] seq_pc;
  logic [AW-1:0] accept_pc;

  // imemaddr doubles as the fetch PC register: in DRAIN it simply holds.
  assign seq_pc = imemaddr + AW'(4);

`ifdef FETCH_JUMP_PREDECODE_EN
  // J/JAL target computed from the accepted word; wraps with the +4 region.
  always_comb begin
    accept_pc = seq_pc;
    if (imemload[31:26] == 6'b000010 || imemload[31:26] == 6'b000011)
      accept_pc = {seq_pc[31:28], imemload[25:0], 2'b00};
  end
`else
  assign accept_pc = seq_pc;
`endif

  // Next-state and next-register values; halt has top priority.
  always_comb begin
    state_d  = state_q;
    fpc_d    = imemaddr;
    pend_d   = pend_q;
    instr_d  = instr;
    pc_d     = pc;
    incpc_d  = incPC;
    valid_d  = valid;
    halted_d = halted;
    if (state_q != HALTED && halt) begin
      state_d  = HALTED;
      valid_d  = 1'b0;
      halted_d = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (redirect_en) begin
            valid_d = 1'b0;
            if (ihit) begin
              fpc_d = redirect_pc;
            end else begin
              // Miss outstanding at the old address: wait for it to return.
              pend_d  = redirect_pc;
              state_d = DRAIN;
            end
          end else if (!stall) begin
            if (ihit) begin
              instr_d = imemload;
              pc_d    = imemaddr;
              incpc_d = seq_pc;
              valid_d = 1'b1;
              fpc_d   = accept_pc;
            end else begin
              valid_d = 1'b0;
            end
          end
        end
        DRAIN: begin
          valid_d = 1'b0;
          if (ihit) begin
            fpc_d   = redirect_en ? redirect_pc : pend_q;
            state_d = RUN;
          end else if (redirect_en) begin
            pend_d = redirect_pc;
          end
        end
        HALTED: ;
        default: state_d = RUN;
      endcase
    end
    ren_d = (state_d != HALTED);
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= RUN;
      imemaddr <= PC_INIT;
      pend_q   <= '0;
      instr    <= '0;
      pc       <= '0;
      incPC    <= '0;
      valid    <= 1'b0;
      halted   <= 1'b0;
      imemREN  <= 1'b1;
    end else begin
      state_q  <= state_d;
      imemaddr <= fpc_d;
      pend_q   <= pend_d;
      instr    <= instr_d;
      pc       <= pc_d;
      incPC    <= incpc_d;
      valid    <= valid_d;
      halted   <= halted_d;
      imemREN  <= ren_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run compared against a transaction-level reference model.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, stall, redirect_en, halt;
  logic [31:0] imemload, redirect_pc;
  logic        imemREN, valid, halted;
  logic [31:0] imemaddr, instr, pc, incPC;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_mode;  // 0 fetching, 1 waiting for miss after redirect, 2 stopped
  logic [31:0] m_fpc, m_pend, m_instr, m_pc, m_inc;
  logic        m_valid, m_halted;

  fetch_unit #(.PC_INIT(32'h00000000)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .stall(stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr), .instr(instr), .pc(pc),
    .incPC(incPC), .valid(valid), .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 1'b0; stall = 1'b0; redirect_en = 1'b0; halt = 1'b0;
    imemload = 32'h0; redirect_pc = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    m_mode = 0; m_fpc = 32'h0; m_pend = 32'h0; m_instr = 32'h0;
    m_pc = 32'h0; m_inc = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
  endtask

  // One clock edge of the architectural behaviour, from the current inputs.
  task automatic model_step();
    logic [31:0] nxt;
    if (m_mode == 2) return;
    if (halt) begin
      m_mode = 2; m_valid = 1'b0; m_halted = 1'b1;
      return;
    end
    if (m_mode == 1) begin
      m_valid = 1'b0;
      if (redirect_en) m_pend = redirect_pc;
      if (ihit) begin m_fpc = m_pend; m_mode = 0; end
      return;
    end
    if (redirect_en) begin
      m_valid = 1'b0;
      if (ihit) m_fpc = redirect_pc;
      else begin m_pend = redirect_pc; m_mode = 1; end
    end else if (!stall) begin
      if (ihit) begin
        m_instr = imemload; m_pc = m_fpc; m_inc = m_fpc + 32'd4; m_valid = 1'b1;
        nxt = m_fpc + 32'd4;
`ifdef FETCH_JUMP_PREDECODE_EN
        if (imemload[31:27] == 5'b00001)
          nxt = {nxt[31:28], imemload[25:0], 2'b00};
`endif
        m_fpc = nxt;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b0;
    #2 RST = 1'b1;
    #1;  // async: no clock edge yet
    n_tests++;
    if (imemREN !== 1'b1 || imemaddr !== 32'h0 || valid !== 1'b0 || halted !== 1'b0 ||
        instr !== 32'h0 || pc !== 32'h0 || incPC !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_async: ren=%b addr=%h valid=%b halted=%b instr=%h pc=%h inc=%h, required 1/0/0/0/0/0/0",
               imemREN, imemaddr, valid, halted, instr, pc, incPC);
    end
    do_reset();
    n_tests++;
    if (imemREN !== 1'b1 || imemaddr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_release: ren=%b addr=%h required 1 00000000", imemREN, imemaddr);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    ihit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imemload = 32'h20010001 + 32'(i);
      tick();
      n_tests++;
      if (valid !== 1'b1 || pc !== 32'(4*i) || incPC !== 32'(4*i+4) ||
          instr !== 32'h20010001 + 32'(i) || imemaddr !== 32'(4*i+4)) begin
        n_fail++;
        $display("FAIL seq_%0d: valid=%b pc=%h inc=%h instr=%h addr=%h required pc=%h", i,
                 valid, pc, incPC, instr, imemaddr, 32'(4*i));
      end
    end
  endtask

  task automatic test_miss_and_stall();
    do_reset();
    ihit = 1'b1; imemload = 32'h20010001;
    tick();
    ihit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (valid !== 1'b0 || imemaddr !== 32'h4) begin
        n_fail++;
        $display("FAIL miss_%0d: valid=%b addr=%h required 0 00000004", i, valid, imemaddr);
      end
    end
    ihit = 1'b1; imemload = 32'h20010002;
    tick();
    n_tests++;
    if (valid !== 1'b1 || pc !== 32'h4 || imemaddr !== 32'h8) begin
      n_fail++;
      $display("FAIL miss_resume: valid=%b pc=%h addr=%h required 1 4 8", valid, pc, imemaddr);
    end
    stall = 1'b1; imemload = 32'h20010003;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (valid !== 1'b1 || pc !== 32'h4 || instr !== 32'h20010002 || imemaddr !== 32'h8) begin
        n_fail++;
        $display("FAIL stall_%0d: valid=%b pc=%h instr=%h addr=%h required 1 4 20010002 8",
                 i, valid, pc, instr, imemaddr);
      end
    end
    stall = 1'b0;
    tick();
    n_tests++;
    if (valid !== 1'b1 || pc !== 32'h8 || instr !== 32'h20010003 || imemaddr !== 32'hC) begin
      n_fail++;
      $display("FAIL stall_release: pc=%h instr=%h addr=%h required 8 20010003 C", pc, instr, imemaddr);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    ihit = 1'b1; imemload = 32'h0;
    tick(); tick();  // now fetching at 8
    ihit = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_en = 1'b0;
    n_tests++;
    if (valid !== 1'b0 || imemaddr !== 32'h8) begin
      n_fail++;
      $display("FAIL drain_enter: valid=%b addr=%h required 0 8", valid, imemaddr);
    end
    redirect_en = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_en = 1'b0; ihit = 1'b1;
    n_tests++;
    if (valid !== 1'b0 || imemaddr !== 32'h8) begin
      n_fail++;
      $display("FAIL drain_hold: valid=%b addr=%h required 0 8", valid, imemaddr);
    end
    tick();
    n_tests++;
    if (valid !== 1'b0 || imemaddr !== 32'h200) begin
      n_fail++;
      $display("FAIL drain_exit: valid=%b addr=%h required 0 200", valid, imemaddr);
    end
    imemload = 32'h20010009;
    tick();
    n_tests++;
    if (valid !== 1'b1 || pc !== 32'h200 || instr !== 32'h20010009) begin
      n_fail++;
      $display("FAIL drain_first: valid=%b pc=%h instr=%h required 1 200 20010009", valid, pc, instr);
    end
    // Redirect with hit beats stall; then wrap at the top of the space.
    stall = 1'b1; redirect_en = 1'b1; redirect_pc = 32'hFFFFFFFC;
    tick();
    stall = 1'b0; redirect_en = 1'b0;
    n_tests++;
    if (valid !== 1'b0 || imemaddr !== 32'hFFFFFFFC) begin
      n_fail++;
      $display("FAIL redirect_over_stall: valid=%b addr=%h required 0 FFFFFFFC", valid, imemaddr);
    end
    imemload = 32'h0;
    tick();
    n_tests++;
    if (valid !== 1'b1 || pc !== 32'hFFFFFFFC || incPC !== 32'h0 || imemaddr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap: pc=%h inc=%h addr=%h required FFFFFFFC 0 0", pc, incPC, imemaddr);
    end
  endtask

  task automatic test_halt();
    logic [31:0] addr_exp;
    do_reset();
    ihit = 1'b1; imemload = 32'h0;
    tick();
    addr_exp = 32'h4;
    halt = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h300; stall = 1'b1;
    tick();
    halt = 1'b0; stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (halted !== 1'b1 || imemREN !== 1'b0 || valid !== 1'b0 || imemaddr !== addr_exp) begin
        n_fail++;
        $display("FAIL halt_%0d: halted=%b ren=%b valid=%b addr=%h required 1 0 0 %h",
                 i, halted, imemREN, valid, imemaddr, addr_exp);
      end
      tick();
    end
    do_reset();
    n_tests++;
    if (halted !== 1'b0 || imemREN !== 1'b1 || imemaddr !== 32'h0) begin
      n_fail++;
      $display("FAIL halt_reset: halted=%b ren=%b addr=%h required 0 1 0", halted, imemREN, imemaddr);
    end
  endtask

  task automatic test_predecode();
    logic [31:0] exp_addr;
`ifdef FETCH_JUMP_PREDECODE_EN
    exp_addr = 32'h100;
`else
    exp_addr = 32'h4;
`endif
    do_reset();
    ihit = 1'b1; imemload = 32'h08000040;
    tick();
    n_tests++;
    if (imemaddr !== exp_addr || pc !== 32'h0 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL predecode: addr=%h pc=%h valid=%b required %h 0 1", imemaddr, pc, valid, exp_addr);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc % 97 == 96) do_reset();  // includes resets mid-drain and mid-halt
      ihit        = ($urandom_range(0, 9) < 6);
      stall       = ($urandom_range(0, 3) == 0);
      redirect_en = ($urandom_range(0, 6) == 0);
      redirect_pc = $urandom() & 32'hFFFFFFFC;
      halt        = ($urandom_range(0, 149) == 0);
      imemload    = $urandom();
      if ($urandom_range(0, 7) == 0) imemload[31:26] = 6'(2 + $urandom_range(0, 1));
      model_step();
      tick();
      n_tests++;
      if (imemaddr !== m_fpc || imemREN !== (m_mode != 2) || valid !== m_valid ||
          halted !== m_halted || (m_valid && (instr !== m_instr || pc !== m_pc || incPC !== m_inc))) begin
        n_fail++;
        $display("FAIL random_%0d: addr=%h ren=%b valid=%b halted=%b instr=%h pc=%h inc=%h required %h %b %b %b %h %h %h",
                 cyc, imemaddr, imemREN, valid, halted, instr, pc, incPC,
                 m_fpc, (m_mode != 2), m_valid, m_halted, m_instr, m_pc, m_inc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_miss_and_stall();
    test_redirect();
    test_halt();
    test_predecode();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
